// File: rtl/cpu_bus_capture_pkg.sv
// Shared types for the CPU bus capture front-end: event fields, synced bus bundle, M2 filter states.
package cpu_bus_capture_pkg;

  localparam int ADDR_W = 15;
  localparam int DAT_W  = 8;

  typedef struct packed {
    logic              rom;
    logic [ADDR_W-1:0] addr;
    logic [DAT_W-1:0]  dat;
  } cpu_evt_t;

  localparam int EVT_W = $bits(cpu_evt_t);

  // Raw CPU bus fields carried through the synchronizer alongside M2.
  typedef struct packed {
    logic              rw;
    logic              ce;
    logic [ADDR_W-1:0] addr;
    logic [DAT_W-1:0]  dat;
  } cpu_bus_t;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } m2_state_e;

endpackage

// File: rtl/cpu_evt_fifo.sv
// Small synchronous FIFO of CPU write events. The head is read straight from the storage
// registers, so a push is never visible before the following cycle (no bypass).
module cpu_evt_fifo
  import cpu_bus_capture_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  cpu_evt_t push_evt,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output cpu_evt_t head_evt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cpu_evt_t       mem_q [DEPTH];
  cpu_evt_t       mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push;
  logic           do_pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    head_evt = empty ? '0 : mem_q[rd_ptr_q];
    do_pop   = pop && !empty;
    // A push into a full FIFO only lands when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_evt;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cpu_bus_capture.sv
// Samples the asynchronous NES CPU bus on clk, filters M2 into clean edge strobes and queues
// CPU write events for the mapper register logic.
module cpu_bus_capture
  import cpu_bus_capture_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int FILT_LEN     = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int STUCK_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m2_in,
  input  logic              cpu_rw_in,
  input  logic              cpu_ce_in,
  input  logic [ADDR_W-1:0] cpu_addr_in,
  input  logic [DAT_W-1:0]  cpu_dat_in,
  output logic              m2_rise,
  output logic              m2_fall,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DAT_W-1:0]  wr_dat,
  output logic              wr_rom,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic              m2_stuck
);

  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam int SCW = $clog2(STUCK_CYCLES + 1);

  cpu_bus_t               bus_raw;
  logic [SYNC_STAGES-1:0] m2_sync_q, m2_sync_d;
  cpu_bus_t               bus_sync_q [SYNC_STAGES];
  cpu_bus_t               bus_sync_d [SYNC_STAGES];
  logic                   m2_s;
  cpu_bus_t               bus_s;

  m2_state_e              state_q, state_d;
  logic [FCW-1:0]         filt_cnt_q, filt_cnt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  cpu_bus_t               shadow_q, shadow_d;
  logic [SCW-1:0]         stuck_q, stuck_d;
  logic                   ovf_q, ovf_d;

  logic                   push;
  cpu_evt_t               push_evt;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   drop;
  cpu_evt_t               head_evt;

  assign bus_raw = {cpu_rw_in, cpu_ce_in, cpu_addr_in, cpu_dat_in};

  // Bus fields ride a chain of the same depth as M2 so a sample and its M2 level stay aligned.
  always_comb begin
    m2_sync_d     = {m2_sync_q[SYNC_STAGES-2:0], m2_in};
    bus_sync_d[0] = bus_raw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      bus_sync_d[i] = bus_sync_q[i-1];
    end
    m2_s  = m2_sync_q[SYNC_STAGES-1];
    bus_s = bus_sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d    = state_q;
    filt_cnt_d = filt_cnt_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    if (m2_s == (state_q == ST_HIGH)) begin
      filt_cnt_d = '0;
    end else if (32'(filt_cnt_q) + 1 >= FILT_LEN) begin
      filt_cnt_d = '0;
      if (state_q == ST_LOW) begin
        state_d = ST_HIGH;
        rise_d  = 1'b1;
      end else begin
        state_d = ST_LOW;
        fall_d  = 1'b1;
      end
    end else begin
      filt_cnt_d = filt_cnt_q + FCW'(1);
    end
  end

  // The shadow keeps the last bus sample taken while M2 was high; it is consumed on m2_fall.
  always_comb begin
    shadow_d = (state_q == ST_HIGH) ? bus_s : shadow_q;
    push     = fall_q && !shadow_q.rw;
    push_evt = '{rom: !shadow_q.ce, addr: shadow_q.addr, dat: shadow_q.dat};
    drop     = push && fifo_full && !(wr_ready && !fifo_empty);
    ovf_d    = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_comb begin
    if (rise_q || fall_q) begin
      stuck_d = '0;
    end else if (stuck_q == SCW'(STUCK_CYCLES)) begin
      stuck_d = stuck_q;
    end else begin
      stuck_d = stuck_q + SCW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m2_sync_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        bus_sync_q[i] <= '0;
      end
      state_q    <= ST_LOW;
      filt_cnt_q <= '0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      shadow_q   <= '0;
      stuck_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      m2_sync_q  <= m2_sync_d;
      bus_sync_q <= bus_sync_d;
      state_q    <= state_d;
      filt_cnt_q <= filt_cnt_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      shadow_q   <= shadow_d;
      stuck_q    <= stuck_d;
      ovf_q      <= ovf_d;
    end
  end

  // Handshake: the head event transfers on a cycle where wr_valid and wr_ready are both high;
  // wr_valid never depends on wr_ready and the head holds steady until it transfers.
  cpu_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_evt (push_evt),
    .pop      (wr_ready),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_evt (head_evt)
  );

  assign m2_rise  = rise_q;
  assign m2_fall  = fall_q;
  assign wr_valid = !fifo_empty;
  assign wr_addr  = head_evt.addr;
  assign wr_dat   = head_evt.dat;
  assign wr_rom   = head_evt.rom;
  assign ovf      = ovf_q;
  assign m2_stuck = (stuck_q == SCW'(STUCK_CYCLES));

endmodule

// File: tb/tb_cpu_bus_capture.sv
// Directed bench for cpu_bus_capture: edge latency, write capture, glitch rejection,
// FIFO overflow, stuck detection and mid-cycle reset.
module tb_cpu_bus_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m2_in = 1'b0;
  logic        cpu_rw_in = 1'b1;
  logic        cpu_ce_in = 1'b1;
  logic [14:0] cpu_addr_in = '0;
  logic [7:0]  cpu_dat_in = '0;
  logic        m2_rise, m2_fall, wr_valid, wr_rom, ovf, m2_stuck;
  logic        wr_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [14:0] wr_addr;
  logic [7:0]  wr_dat;

  int n_cmp = 0;
  int n_err = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int r0, f0;
  logic [23:0] exp_q[$];

  cpu_bus_capture dut (
    .clk         (clk),
    .rst         (rst),
    .m2_in       (m2_in),
    .cpu_rw_in   (cpu_rw_in),
    .cpu_ce_in   (cpu_ce_in),
    .cpu_addr_in (cpu_addr_in),
    .cpu_dat_in  (cpu_dat_in),
    .m2_rise     (m2_rise),
    .m2_fall     (m2_fall),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_dat      (wr_dat),
    .wr_rom      (wr_rom),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr),
    .m2_stuck    (m2_stuck)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m2_rise) rise_cnt++;
    if (m2_fall) fall_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic set_bus(input logic rw, input logic ce, input logic [14:0] addr,
                         input logic [7:0] dat);
    cpu_rw_in   = rw;
    cpu_ce_in   = ce;
    cpu_addr_in = addr;
    cpu_dat_in  = dat;
  endtask

  task automatic cpu_cycle(input logic rw, input logic ce, input logic [14:0] addr,
                           input logic [7:0] dat);
    set_bus(rw, ce, addr, dat);
    m2_in = 1'b1;
    ticks(8);
    m2_in = 1'b0;
    ticks(8);
  endtask

  // Scoreboard: compare head against the oldest expected event, then pop it
  task automatic pop_check(input string tag);
    logic [23:0] exp_evt;
    exp_evt = exp_q.pop_front();
    chk({tag, "_valid"}, 32'(wr_valid), 32'd1);
    chk({tag, "_evt"}, 32'({wr_rom, wr_addr, wr_dat}), 32'(exp_evt));
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    ticks(3);
    chk("rst_rise", 32'(m2_rise), 0);
    chk("rst_fall", 32'(m2_fall), 0);
    chk("rst_valid", 32'(wr_valid), 0);
    chk("rst_head", 32'({wr_rom, wr_addr, wr_dat}), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_stuck", 32'(m2_stuck), 0);
    rst = 1'b0;
    ticks(2);

    // 1: clean write cycle, edge latency 5 clocks
    set_bus(1'b0, 1'b0, 15'h0000, 8'hC5);
    m2_in = 1'b1;
    ticks(4);
    chk("t1_rise_early", 32'(m2_rise), 0);
    tick();
    chk("t1_rise", 32'(m2_rise), 1);
    tick();
    chk("t1_rise_end", 32'(m2_rise), 0);
    ticks(2);
    m2_in = 1'b0;
    ticks(4);
    chk("t1_fall_early", 32'(m2_fall), 0);
    tick();
    chk("t1_fall", 32'(m2_fall), 1);
    chk("t1_valid_early", 32'(wr_valid), 0);
    tick();
    chk("t1_fall_end", 32'(m2_fall), 0);
    chk("t1_valid", 32'(wr_valid), 1);
    chk("t1_addr", 32'(wr_addr), 32'h0000);
    chk("t1_dat", 32'(wr_dat), 32'hC5);
    chk("t1_rom", 32'(wr_rom), 1);
    ticks(2);
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    chk("t1_popped", 32'(wr_valid), 0);

    // 2: read cycle strobes but pushes nothing
    f0 = fall_cnt;
    cpu_cycle(1'b1, 1'b0, 15'h4000, 8'h99);
    chk("t2_fall_cnt", 32'(fall_cnt - f0), 1);
    chk("t2_valid", 32'(wr_valid), 0);

    // 3: two-cycle low glitch while high is rejected
    r0 = rise_cnt;
    f0 = fall_cnt;
    set_bus(1'b0, 1'b0, 15'h2001, 8'h77);
    m2_in = 1'b1;
    ticks(8);
    m2_in = 1'b0;
    ticks(2);
    m2_in = 1'b1;
    ticks(10);
    chk("t3_rise_cnt", 32'(rise_cnt - r0), 1);
    chk("t3_fall_cnt", 32'(fall_cnt - f0), 0);
    chk("t3_valid", 32'(wr_valid), 0);
    m2_in = 1'b0;
    ticks(4);
    chk("t3_fall_early", 32'(m2_fall), 0);
    tick();
    chk("t3_fall", 32'(m2_fall), 1);
    ticks(3);
    exp_q.push_back({1'b1, 15'h2001, 8'h77});
    pop_check("t3_evt");

    // 4: overflow with consumer stalled
    for (int i = 1; i <= 5; i++) begin
      cpu_cycle(1'b0, 1'b1, 15'h0100 + 15'(i), 8'(i));
      if (i <= 4) exp_q.push_back({1'b0, 15'h0100 + 15'(i), 8'(i)});
      chk("t4_ovf", 32'(ovf), (i == 5) ? 1 : 0);
    end
    set_bus(1'b0, 1'b1, 15'h0106, 8'h06);
    m2_in = 1'b1;
    ticks(8);
    m2_in = 1'b0;
    ticks(5);
    chk("t4_drop_fall", 32'(m2_fall), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_set_wins", 32'(ovf), 1);
    ticks(2);
    for (int i = 0; i < 4; i++) pop_check("t4_pop");
    chk("t4_empty", 32'(wr_valid), 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(ovf), 0);

    // 5: stuck detection
    chk("t5_not_stuck", 32'(m2_stuck), 0);
    ticks(4100);
    chk("t5_stuck", 32'(m2_stuck), 1);
    set_bus(1'b1, 1'b1, 15'h0000, 8'h00);
    m2_in = 1'b1;
    ticks(5);
    chk("t5_rise", 32'(m2_rise), 1);
    chk("t5_stuck_hold", 32'(m2_stuck), 1);
    tick();
    chk("t5_unstuck", 32'(m2_stuck), 0);
    ticks(2);
    m2_in = 1'b0;
    ticks(8);

    // 6: reset with entries queued and a falling edge mid-filter
    cpu_cycle(1'b0, 1'b0, 15'h0011, 8'hA1);
    cpu_cycle(1'b0, 1'b0, 15'h0012, 8'hA2);
    chk("t6_queued", 32'(wr_valid), 1);
    set_bus(1'b1, 1'b0, 15'h0000, 8'h00);
    m2_in = 1'b1;
    ticks(8);
    m2_in = 1'b0;
    ticks(2);
    rst = 1'b1;
    #1;
    chk("t6_valid", 32'(wr_valid), 0);
    chk("t6_head", 32'({wr_rom, wr_addr, wr_dat}), 0);
    chk("t6_strobes", 32'({m2_rise, m2_fall}), 0);
    chk("t6_ovf_stuck", 32'({ovf, m2_stuck}), 0);
    exp_q.delete();
    ticks(3);
    rst = 1'b0;
    r0 = rise_cnt;
    f0 = fall_cnt;
    ticks(12);
    chk("t6_no_rise", 32'(rise_cnt - r0), 0);
    chk("t6_no_fall", 32'(fall_cnt - f0), 0);
    chk("t6_still_empty", 32'(wr_valid), 0);
    cpu_cycle(1'b0, 1'b0, 15'h7FFF, 8'h5A);
    exp_q.push_back({1'b1, 15'h7FFF, 8'h5A});
    pop_check("t6_evt");
    chk("t6_final_empty", 32'(wr_valid), 0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
